// File: rtl/cam_capture.sv
//==============================================================================
// Module   : cam_capture
// Purpose  : Captures an 8-bit parallel camera stream (PCLK/VSYNC/HREF/DATA)
//            into RGB565 pixels with linear addresses, all within the single
//            system clock domain. The camera pixel clock is oversampled as
//            data and is never used as a clock.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   IMG_W          active pixels per line
//   IMG_H          active lines per frame
// Ports
//   i_clk          system clock (only clock)
//   i_rst          synchronous active-high reset
//   i_cfg_done     level, camera register configuration complete
//   i_pclk         camera pixel clock (asynchronous, <= i_clk/4)
//   i_vsync        camera VSYNC, high in vertical blanking
//   i_href         camera HREF, high while line bytes are valid
//   i_data[7:0]    camera byte bus
//   o_pix_data     RGB565 pixel, first byte in [15:8]
//   o_pix_valid    one-cycle strobe qualifying o_pix_data / o_pix_addr
//   o_pix_addr     linear pixel index row*IMG_W+col
//   o_sof          one-cycle strobe at frame start
//   o_frame_done   one-cycle strobe at frame end
//   o_size_err     sticky, a frame ended with the wrong pixel count
//==============================================================================
`default_nettype none

module cam_capture #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cfg_done,
    input  logic        i_pclk,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic [7:0]  i_data,
    output logic [15:0] o_pix_data,
    output logic        o_pix_valid,
    output logic [16:0] o_pix_addr,
    output logic        o_sof,
    output logic        o_frame_done,
    output logic        o_size_err
);

    localparam logic [16:0] c_PIX_TOTAL = 17'(IMG_W * IMG_H);

    typedef enum logic [1:0] {
        WAIT_CFG     = 2'd0,
        WAIT_VS_HIGH = 2'd1,
        WAIT_VS_LOW  = 2'd2,
        CAPTURE      = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Camera inputs are bundled so every bit passes through the same number
    // of flops; HREF/DATA therefore line up exactly with the detected PCLK
    // edge. Bundle order: {pclk, vsync, href, data[7:0]}.
    logic [10:0] r_sync1;
    logic [10:0] r_sync2;

    logic        w_pclk_s;
    logic        w_vsync_s;
    logic        w_href_s;
    logic [7:0]  w_data_s;

    logic        r_pclk_prev;
    logic        r_vsync_prev;

    logic        w_pclk_rise;
    logic        w_vs_rise;
    logic        w_vs_fall;

    // Datapath control decoded from the FSM.
    logic        w_sof;
    logic        w_done;
    logic        w_sample;

    logic        r_phase;
    logic [7:0]  r_hi_byte;
    logic [16:0] r_count;
    logic        r_overflow;

    //--------------------------------------------------------------------------
    // Input synchronizers and edge detection
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_pclk_prev  <= 1'b0;
            r_vsync_prev <= 1'b0;
        end else begin
            r_sync1      <= {i_pclk, i_vsync, i_href, i_data};
            r_sync2      <= r_sync1;
            r_pclk_prev  <= w_pclk_s;
            r_vsync_prev <= w_vsync_s;
        end
    end

    assign w_pclk_s    = r_sync2[10];
    assign w_vsync_s   = r_sync2[9];
    assign w_href_s    = r_sync2[8];
    assign w_data_s    = r_sync2[7:0];

    assign w_pclk_rise = w_pclk_s & ~r_pclk_prev;
    assign w_vs_rise   = w_vsync_s & ~r_vsync_prev;
    assign w_vs_fall   = ~w_vsync_s & r_vsync_prev;

    //--------------------------------------------------------------------------
    // Control FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= WAIT_CFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Control FSM: next state and datapath strobes
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sof       = 1'b0;
        w_done      = 1'b0;
        w_sample    = 1'b0;

        // Losing configuration overrides everything and silences all strobes.
        if (!i_cfg_done) begin
            w_state_nxt = WAIT_CFG;
        end else begin
            case (r_state)
                WAIT_CFG: begin
                    w_state_nxt = WAIT_VS_HIGH;
                end
                // Waiting for blanking first guarantees we never lock onto
                // the middle of a frame that was already in flight.
                WAIT_VS_HIGH: begin
                    if (w_vsync_s) begin
                        w_state_nxt = WAIT_VS_LOW;
                    end
                end
                WAIT_VS_LOW: begin
                    if (w_vs_fall) begin
                        w_state_nxt = CAPTURE;
                        w_sof       = 1'b1;
                    end
                end
                CAPTURE: begin
                    // Frame end wins over a coincident byte sample.
                    if (w_vs_rise) begin
                        w_state_nxt = WAIT_VS_LOW;
                        w_done      = 1'b1;
                    end else if (w_pclk_rise) begin
                        w_sample    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = WAIT_CFG;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Byte assembly, pixel counter and registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase      <= 1'b0;
            r_hi_byte    <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            o_pix_data   <= '0;
            o_pix_valid  <= 1'b0;
            o_pix_addr   <= '0;
            o_sof        <= 1'b0;
            o_frame_done <= 1'b0;
            o_size_err   <= 1'b0;
        end else begin
            o_pix_valid  <= 1'b0;
            o_sof        <= w_sof;
            o_frame_done <= w_done;

            if (w_sof) begin
                r_phase    <= 1'b0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end

            if (w_sample) begin
                if (!w_href_s) begin
                    // Line gap: any unpaired trailing byte is dropped.
                    r_phase <= 1'b0;
                end else if (!r_phase) begin
                    r_hi_byte <= w_data_s;
                    r_phase   <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    if (r_count < c_PIX_TOTAL) begin
                        o_pix_valid <= 1'b1;
                        o_pix_data  <= {r_hi_byte, w_data_s};
                        o_pix_addr  <= r_count;
                        r_count     <= r_count + 17'd1;
                    end else begin
                        // The counter saturates at the frame size, so a
                        // separate flag remembers that extra pixels arrived.
                        r_overflow <= 1'b1;
                    end
                end
            end

            if (w_done && ((r_count != c_PIX_TOTAL) || r_overflow)) begin
                o_size_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cam_capture.sv
//==============================================================================
// Module   : tb_cam_capture
// Purpose  : Self-checking bench for cam_capture on a 4x2 image.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cam_capture;

    localparam int TB_W = 4;
    localparam int TB_H = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_done;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic [16:0] pix_addr;
    logic        sof;
    logic        frame_done;
    logic        size_err;

    cam_capture #(
        .IMG_W (TB_W),
        .IMG_H (TB_H)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cfg_done   (cfg_done),
        .i_pclk       (pclk),
        .i_vsync      (vsync),
        .i_href       (href),
        .i_data       (data),
        .o_pix_data   (pix_data),
        .o_pix_valid  (pix_valid),
        .o_pix_addr   (pix_addr),
        .o_sof        (sof),
        .o_frame_done (frame_done),
        .o_size_err   (size_err)
    );

    always #5 clk = ~clk;

    // Monitor: records every strobe; the test only reads these.
    logic [15:0] q_data[$];
    logic [16:0] q_addr[$];
    int          sof_cnt  = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (pix_valid) begin
            q_data.push_back(pix_data);
            q_addr.push_back(pix_addr);
        end
        if (sof)        sof_cnt  = sof_cnt + 1;
        if (frame_done) done_cnt = done_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One camera byte period = 8 system clocks (PCLK at clk/8).
    task automatic cam_byte(input logic [7:0] b, input logic h);
        data = b;
        href = h;
        pclk = 1'b0;
        repeat (4) @(negedge clk);
        pclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic cam_idle(input int n);
        for (int i = 0; i < n; i++) cam_byte(8'h00, 1'b0);
    endtask

    task automatic line_px(input logic [7:0] hi, input logic [7:0] lo, input int n);
        for (int i = 0; i < n; i++) begin
            cam_byte(hi, 1'b1);
            cam_byte(lo, 1'b1);
        end
        cam_idle(2);
    endtask

    task automatic vs_high();
        vsync = 1'b1;
        cam_idle(3);
    endtask

    task automatic vs_low();
        vsync = 1'b0;
        cam_idle(3);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_data;
        logic [16:0] exp_addr;
    } vec_t;

    vec_t tbl[8];

    int base;
    int sof0;
    int done0;

    initial begin
        tbl[0] = '{8'hF8, 8'h1F, 16'hF81F, 17'd0};
        tbl[1] = '{8'hF8, 8'h1F, 16'hF81F, 17'd1};
        tbl[2] = '{8'h12, 8'h34, 16'h1234, 17'd2};
        tbl[3] = '{8'hAB, 8'hCD, 16'hABCD, 17'd3};
        tbl[4] = '{8'h00, 8'hFF, 16'h00FF, 17'd4};
        tbl[5] = '{8'hFF, 8'h00, 16'hFF00, 17'd5};
        tbl[6] = '{8'h5A, 8'hA5, 16'h5AA5, 17'd6};
        tbl[7] = '{8'h80, 8'h01, 16'h8001, 17'd7};

        rst = 1'b0; cfg_done = 1'b0; pclk = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
        apply_reset();

        // ---- reset state ----
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_data",  32'(pix_data),  32'd0);
        check("rst_addr",  32'(pix_addr),  32'd0);
        check("rst_sof",   32'(sof),       32'd0);
        check("rst_done",  32'(frame_done),32'd0);
        check("rst_err",   32'(size_err),  32'd0);

        // ---- configuration gating: full frame with cfg_done low ----
        base = q_data.size(); sof0 = sof_cnt;
        vs_high(); vs_low();
        line_px(8'hF8, 8'h1F, TB_W);
        line_px(8'hF8, 8'h1F, TB_W);
        vs_high(); vs_low();
        check("gate_pix", 32'(q_data.size() - base), 32'd0);
        check("gate_sof", 32'(sof_cnt - sof0),        32'd0);

        // ---- nominal frame, table driven ----
        cfg_done = 1'b1;
        cam_idle(2);
        base = q_data.size(); sof0 = sof_cnt; done0 = done_cnt;
        vs_high(); vs_low();
        for (int l = 0; l < TB_H; l++) begin
            for (int c = 0; c < TB_W; c++) begin
                cam_byte(tbl[l*TB_W+c].hi, 1'b1);
                cam_byte(tbl[l*TB_W+c].lo, 1'b1);
            end
            cam_idle(2);
        end
        vs_high();
        check("nom_count", 32'(q_data.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("nom_data", (base + i < q_data.size()) ? 32'(q_data[base+i]) : 32'hDEAD_BEEF, 32'(tbl[i].exp_data));
            check("nom_addr", (base + i < q_addr.size()) ? 32'(q_addr[base+i]) : 32'hDEAD_BEEF, 32'(tbl[i].exp_addr));
        end
        check("nom_sof",  32'(sof_cnt - sof0),   32'd1);
        check("nom_done", 32'(done_cnt - done0), 32'd1);
        check("nom_err",  32'(size_err),         32'd0);
        check("hold_data", 32'(pix_data), 32'h8001);
        check("hold_addr", 32'(pix_addr), 32'd7);

        // ---- odd line: 9 bytes, trailing byte dropped ----
        base = q_data.size();
        vs_low();
        for (int i = 0; i < TB_W; i++) begin
            cam_byte(8'hF8, 1'b1);
            cam_byte(8'h1F, 1'b1);
        end
        cam_byte(8'hAA, 1'b1);
        cam_idle(2);
        line_px(8'h12, 8'h34, TB_W);
        vs_high();
        check("odd_count", 32'(q_data.size() - base), 32'd8);
        check("odd_addr4", (base + 4 < q_addr.size()) ? 32'(q_addr[base+4]) : 32'hDEAD_BEEF, 32'd4);
        check("odd_data4", (base + 4 < q_data.size()) ? 32'(q_data[base+4]) : 32'hDEAD_BEEF, 32'h1234);
        check("odd_err", 32'(size_err), 32'd0);

        // ---- oversize frame: 10 pixels ----
        base = q_data.size();
        vs_low();
        line_px(8'h01, 8'h02, TB_W);
        line_px(8'h03, 8'h04, TB_W);
        line_px(8'h05, 8'h06, 2);
        vs_high();
        check("over_count", 32'(q_data.size() - base), 32'd8);
        check("over_last",  32'(pix_addr), 32'd7);
        check("over_err",   32'(size_err), 32'd1);

        // ---- correct frame afterwards: error stays sticky ----
        base = q_data.size();
        vs_low();
        line_px(8'h07, 8'h08, TB_W);
        line_px(8'h09, 8'h0A, TB_W);
        vs_high();
        check("sticky_count", 32'(q_data.size() - base), 32'd8);
        check("sticky_err",   32'(size_err), 32'd1);

        // ---- cfg_done drops mid-frame: no further strobes ----
        base = q_data.size(); done0 = done_cnt;
        vs_low();
        line_px(8'h11, 8'h22, TB_W);
        cfg_done = 1'b0;
        line_px(8'h33, 8'h44, TB_W);
        vs_high();
        check("cfgdrop_count", 32'(q_data.size() - base), 32'd4);
        check("cfgdrop_done",  32'(done_cnt - done0),     32'd0);

        // ---- reset clears sticky error; mid-frame start ----
        vsync = 1'b0;
        apply_reset();
        check("rst2_err", 32'(size_err), 32'd0);
        base = q_data.size(); sof0 = sof_cnt;
        cam_byte(8'h55, 1'b1);
        cam_byte(8'h66, 1'b1);
        cfg_done = 1'b1;
        for (int i = 0; i < 6; i++) cam_byte(8'h77, 1'b1);
        cam_idle(2);
        line_px(8'h88, 8'h99, TB_W);
        check("mid_nopix", 32'(q_data.size() - base), 32'd0);
        check("mid_nosof", 32'(sof_cnt - sof0),        32'd0);
        vs_high(); vs_low();
        line_px(8'hC0, 8'hDE, TB_W);
        line_px(8'hC0, 8'hDE, TB_W);
        vs_high();
        check("mid_count", 32'(q_data.size() - base), 32'd8);
        check("mid_addr0", (base < q_addr.size()) ? 32'(q_addr[base]) : 32'hDEAD_BEEF, 32'd0);
        check("mid_err",   32'(size_err), 32'd0);

        // ---- reset mid-line after 3 pixels ----
        done0 = done_cnt;
        vs_low();
        for (int i = 0; i < 3; i++) begin
            cam_byte(8'hE1, 1'b1);
            cam_byte(8'hE2, 1'b1);
        end
        cam_byte(8'hE3, 1'b1);
        check("pre_rst_addr", 32'(pix_addr), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data",  32'(pix_data),  32'd0);
        check("midrst_addr",  32'(pix_addr),  32'd0);
        check("midrst_valid", 32'(pix_valid), 32'd0);
        rst = 1'b0;
        cam_byte(8'hE4, 1'b1);
        cam_idle(2);
        vs_high();
        check("midrst_nodone", 32'(done_cnt - done0), 32'd0);
        base = q_data.size();
        vs_low();
        line_px(8'h3C, 8'h3D, TB_W);
        line_px(8'h3C, 8'h3D, TB_W);
        vs_high();
        check("after_rst_count", 32'(q_data.size() - base), 32'd8);
        check("after_rst_addr0", (base < q_addr.size()) ? 32'(q_addr[base]) : 32'hDEAD_BEEF, 32'd0);
        check("after_rst_done",  32'(done_cnt - done0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
